snn_network_ctrl: RTL and testbench

- Run sequencer directly downstream of the AXI config register block.
- Consumes the `ctrl` and `sim_time` register outputs and steps the spiking network through `sim_time` timesteps.
- Each timestep: fetches the input spike pattern from pattern memory, pulses the neuron array, then waits for it to settle.
- Produces the `network_busy` and `done` status bits that the register block reads back into ctrl[2] and ctrl[3].

---
 rtl/snn_network_ctrl.sv | 152 +++++++++++++++
 tb/tb_snn_network_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_network_ctrl.sv
// rtl/snn_network_ctrl.sv - run sequencer stepping the spiking network through sim_time timesteps
// Optional feature macro: SNN_RUN_CYCLE_COUNT_EN adds the run_cycles busy-cycle counter output.
module snn_network_ctrl #(
   parameter int TIME_WIDTH         = 32,
   parameter int PATTERN_ADDR_WIDTH = 8,
   parameter int MEM_READ_LATENCY   = 1,
   parameter int SETTLE_CYCLES      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   ctrl,
   input  logic [TIME_WIDTH-1:0]         sim_time,
   output logic                          network_busy,
   output logic                          done,
   output logic [PATTERN_ADDR_WIDTH-1:0] pattern_addr,
   output logic                          pattern_rden,
   output logic                          neuron_step,
   output logic                          clear_counters,
`ifdef SNN_RUN_CYCLE_COUNT_EN
   output logic [31:0]                   run_cycles,
`endif
   output logic [TIME_WIDTH-1:0]         timestep
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_STEP,
      S_SETTLE,
      S_FIN
   } state_t;

   localparam logic [3:0] FETCH_LAST  = 4'(MEM_READ_LATENCY - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t                  state;
   logic [3:0]              cnt;
   logic                    ctrl0_q;
   logic                    ctrl1_q;
   logic [TIME_WIDTH-1:0]   sim_time_q;
   logic [TIME_WIDTH-1:0]   ts_inc;
   logic                    start_evt;
   logic                    abort_evt;
   logic                    unused_ctrl;

   assign start_evt   = ctrl[0] & ~ctrl0_q;
   assign abort_evt   = ctrl[1] & ~ctrl1_q;
   assign ts_inc      = timestep + 1'b1;
   assign unused_ctrl = ^ctrl[31:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         ctrl0_q        <= 1'b0;
         ctrl1_q        <= 1'b0;
         sim_time_q     <= '0;
         network_busy   <= 1'b0;
         done           <= 1'b0;
         pattern_addr   <= '0;
         pattern_rden   <= 1'b0;
         neuron_step    <= 1'b0;
         clear_counters <= 1'b0;
         timestep       <= '0;
      end else begin
         ctrl0_q        <= ctrl[0];
         ctrl1_q        <= ctrl[1];
         clear_counters <= 1'b0;
         // Abort takes priority over everything, including a coincident start.
         if (abort_evt) begin
            state          <= S_IDLE;
            cnt            <= '0;
            network_busy   <= 1'b0;
            done           <= 1'b0;
            clear_counters <= 1'b1;
            timestep       <= '0;
            pattern_addr   <= '0;
            pattern_rden   <= 1'b0;
            neuron_step    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_evt) begin
                     sim_time_q     <= sim_time;
                     timestep       <= '0;
                     done           <= 1'b0;
                     clear_counters <= 1'b1;
                     network_busy   <= 1'b1;
                     cnt            <= '0;
                     pattern_addr   <= '0;
                     if (sim_time != '0) begin
                        state        <= S_FETCH;
                        pattern_rden <= 1'b1;
                     end else begin
                        state <= S_FIN;
                     end
                  end
               end
               S_FETCH: begin
                  if (cnt == FETCH_LAST) begin
                     state        <= S_STEP;
                     cnt          <= '0;
                     pattern_rden <= 1'b0;
                     neuron_step  <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_STEP: begin
                  state       <= S_SETTLE;
                  neuron_step <= 1'b0;
               end
               S_SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt <= '0;
                     // Compare before increment so sim_time of all-ones cannot overflow.
                     if (timestep == sim_time_q - 1'b1) begin
                        state <= S_FIN;
                     end else begin
                        state        <= S_FETCH;
                        timestep     <= ts_inc;
                        pattern_addr <= ts_inc[PATTERN_ADDR_WIDTH-1:0];
                        pattern_rden <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_FIN: begin
                  state        <= S_IDLE;
                  network_busy <= 1'b0;
                  done         <= 1'b1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SNN_RUN_CYCLE_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst || abort_evt) begin
         run_cycles <= '0;
      end else if (state == S_IDLE && start_evt) begin
         run_cycles <= '0;
      end else if (network_busy && run_cycles != 32'hFFFF_FFFF) begin
         run_cycles <= run_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_snn_network_ctrl.sv
// tb/tb_snn_network_ctrl.sv - scoreboard bench for snn_network_ctrl (default and 2-bit address instances)
module tb_snn_network_ctrl;

   localparam int K_CLR  = 0;
   localparam int K_STEP = 1;
   localparam int K_END  = 2;

   typedef struct {
      int kind;
      int ts;
      int gap;
      int len;
      int dn;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl;
   logic [31:0] sim_time;

   logic        busy, done, rden, step, clr;
   logic [7:0]  addr;
   logic [31:0] ts;
   logic        b_busy, b_done, b_rden, b_step, b_clr;
   logic [1:0]  b_addr;
   logic [31:0] b_ts;
`ifdef SNN_RUN_CYCLE_COUNT_EN
   logic [31:0] run_cycles;
   logic [31:0] b_run_cycles;
`endif

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  busy_len = 0;
   int  last_step = 0;
   bit  busy_prev = 1'b0;
   bit  rden_prev = 1'b0;

   always #5 clk = ~clk;

   snn_network_ctrl dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .sim_time(sim_time),
      .network_busy(busy), .done(done), .pattern_addr(addr), .pattern_rden(rden),
      .neuron_step(step), .clear_counters(clr),
`ifdef SNN_RUN_CYCLE_COUNT_EN
      .run_cycles(run_cycles),
`endif
      .timestep(ts)
   );

   snn_network_ctrl #(.PATTERN_ADDR_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .ctrl(ctrl), .sim_time(sim_time),
      .network_busy(b_busy), .done(b_done), .pattern_addr(b_addr), .pattern_rden(b_rden),
      .neuron_step(b_step), .clear_counters(b_clr),
`ifdef SNN_RUN_CYCLE_COUNT_EN
      .run_cycles(b_run_cycles),
`endif
      .timestep(b_ts)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop(input int kind, output ev_t e);
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
         e = '{kind: kind, ts: 0, gap: 0, len: 0, dn: 0};
      end else begin
         e = q.pop_front();
         if (e.kind != kind) begin
            errors++;
            $display("FAIL event_kind: got %0d expected %0d (t=%0t)", kind, e.kind, $time);
         end
      end
   endtask

   // Monitor: pops the expected event whenever the DUT presents one.
   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (clr) begin
         pop(K_CLR, e);
         chk("clr_b", b_clr, 1);
      end
      if (busy && !busy_prev) busy_len = 0;
      if (busy) busy_len++;
      if (!busy && busy_prev) begin
         pop(K_END, e);
         chk("busy_len", busy_len, e.len);
         chk("done", done, e.dn);
         chk("done_b", b_done, e.dn);
         chk("idle_b", {b_busy, b_rden}, 0);
      end
      if (step) begin
         pop(K_STEP, e);
         chk("addr", addr, e.ts % 256);
         chk("addr_b", b_addr, e.ts % 4);
         chk("timestep", ts, e.ts);
         chk("timestep_b", b_ts, e.ts);
         chk("step_b", b_step, 1);
         chk("rden_before_step", rden_prev, 1);
         if (e.gap != 0) chk("step_gap", cyc - last_step, e.gap);
         last_step = cyc;
      end
      busy_prev = busy;
      rden_prev = rden;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input int t, input int gap, input int len, input int dn);
      q.push_back('{kind: kind, ts: t, gap: gap, len: len, dn: dn});
   endtask

   task automatic push_steps(input int n);
      for (int t = 0; t < n; t++) push(K_STEP, t, (t == 0) ? 0 : 4, 0, 0);
   endtask

   task automatic push_run(input int n);
      push(K_CLR, 0, 0, 0, 0);
      push_steps(n);
      push(K_END, 0, 0, n * 4 + 1, 1);
   endtask

   task automatic start_pulse();
      ctrl = 32'h1;
      tick(1);
      ctrl = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      ctrl = 32'h0;
      sim_time = 32'd0;
      tick(3);
      chk("reset_outputs", {busy, done, rden, step, clr, addr, ts}, 0);
      rst = 1'b0;
      tick(2);

      // Basic run
      sim_time = 32'd3;
      push_run(3);
      start_pulse();
      tick(18);
      chk("drain_basic", q.size(), 0);
      chk("done_held", {busy, done}, 2'b01);
`ifdef SNN_RUN_CYCLE_COUNT_EN
      chk("run_cycles", run_cycles, 13);
`endif

      // Zero-length run
      sim_time = 32'd0;
      push_run(0);
      start_pulse();
      tick(5);
      chk("drain_zero", q.size(), 0);

      // Start while busy, held level, sim_time change mid-run
      sim_time = 32'd5;
      push_run(5);
      start_pulse();
      tick(5);
      sim_time = 32'd9;
      ctrl = 32'h1;
      tick(20);
      ctrl = 32'h0;
      tick(5);
      chk("drain_held", q.size(), 0);
      chk("no_restart", {busy, done}, 2'b01);

      // Abort on 2nd SETTLE cycle of timestep 4
      sim_time = 32'd10;
      push(K_CLR, 0, 0, 0, 0);
      push_steps(5);
      push(K_CLR, 0, 0, 0, 0);
      push(K_END, 0, 0, 20, 0);
      start_pulse();
      tick(19);
      ctrl = 32'h2;
      tick(1);
      ctrl = 32'h0;
      chk("abort_state", {busy, done, step, ts}, 0);
`ifdef SNN_RUN_CYCLE_COUNT_EN
      chk("run_cycles_abort", run_cycles, 0);
`endif
      tick(10);
      chk("drain_abort", q.size(), 0);
      push_run(10);
      start_pulse();
      tick(46);
      chk("drain_rerun", q.size(), 0);

      // Address wrap on the 2-bit instance
      sim_time = 32'd6;
      push_run(6);
      start_pulse();
      tick(30);
      chk("drain_wrap", q.size(), 0);
      chk("ts_final", ts, 5);
      chk("ts_final_b", b_ts, 5);

      // Simultaneous start and abort in IDLE
      push(K_CLR, 0, 0, 0, 0);
      ctrl = 32'h3;
      tick(1);
      ctrl = 32'h0;
      chk("simul_state", {busy, done}, 0);
      tick(5);
      chk("drain_simul", q.size(), 0);
      chk("simul_idle", busy, 0);

      // rst during FETCH
      sim_time = 32'd3;
      push(K_CLR, 0, 0, 0, 0);
      push(K_END, 0, 0, 1, 0);
      start_pulse();
      rst = 1'b1;
      tick(1);
      chk("rst_outputs", {busy, done, rden, step, clr, addr, ts}, 0);
`ifdef SNN_RUN_CYCLE_COUNT_EN
      chk("run_cycles_rst", run_cycles, 0);
`endif
      rst = 1'b0;
      tick(5);
      chk("drain_rst", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
